sram_io_ctrl: RTL and testbench



---
 rtl/sram_io_ctrl_pkg.sv | 24 ++
 rtl/sram_io_shreg.sv | 48 ++++
 rtl/sram_io_ctrl.sv | 159 +++++++++++++++
 tb/tb_sram_io_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sram_io_ctrl_pkg.sv
// sram_io_ctrl_pkg: shared widths, CTRL mode encodings and FSM state
// encoding for the serial-to-parallel SRAM bridge.
// Optional build macro SRAM_IO_CTRL_AUTOINC_EN is consumed in sram_io_ctrl.sv.
package sram_io_ctrl_pkg;

  localparam int MEMORY_DATA_WIDTH = 8;
  localparam int MEMORY_ADDR_WIDTH = 9;
  localparam int REG_BITS_WIDTH    = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH;

  localparam logic [1:0] MODE_SHIFT = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_NOP   = 2'b10;
  localparam logic [1:0] MODE_WRITE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT    = 3'd1,
    ST_WRITE    = 3'd2,
    ST_READ     = 3'd3,
    ST_READ_CAP = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

endpackage

// File: rtl/sram_io_shreg.sv
// sram_io_shreg: {address, data} register of the bridge.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   shift_en_i     : shift right, si_i enters at the MSB
//   si_i           : serial input bit
//   load_en_i      : replace data field with load_data_i
//   load_data_i    : parallel data (SRAM Q)
//   addr_inc_i     : increment address field (wraps)
//   reg_bits_o     : {address, data}
module sram_io_shreg
  import sram_io_ctrl_pkg::*;
#(
  parameter int DW = MEMORY_DATA_WIDTH,
  parameter int AW = MEMORY_ADDR_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             shift_en_i,
  input  logic             si_i,
  input  logic             load_en_i,
  input  logic [DW-1:0]    load_data_i,
  input  logic             addr_inc_i,
  output logic [AW+DW-1:0] reg_bits_o
);

  localparam int W = AW + DW;

  logic [W-1:0] reg_q, reg_d;

  // Shift has priority; load and increment touch disjoint fields so they
  // may happen in the same cycle (read capture with auto-increment).
  always_comb begin
    reg_d = reg_q;
    if (shift_en_i) begin
      reg_d = {si_i, reg_q[W-1:1]};
    end else begin
      if (load_en_i)  reg_d[DW-1:0] = load_data_i;
      if (addr_inc_i) reg_d[W-1:DW] = reg_q[W-1:DW] + {{(AW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) reg_q <= '0;
    else          reg_q <= reg_d;
  end

  assign reg_bits_o = reg_q;

endmodule

// File: rtl/sram_io_ctrl.sv
// sram_io_ctrl: host serial port to 512x8 SRAM bridge.
//   CLK, RST_N : clock, synchronous active-low reset
//   BGN        : operation enable, held high for the whole operation
//   SI         : serial in, LSB first
//   LOAD_N     : active-low operation trigger
//   CTRL       : 00 shift, 01 read, 11 write, 10 no-op
//   PI         : SRAM Q
//   RDY        : operation complete
//   D_WE, CEN  : SRAM WEN / CEN, active low
//   SO, A, PO  : reg_bits[0], address field, data field
// Build macro SRAM_IO_CTRL_AUTOINC_EN: address field increments after each
// write or read access.
module sram_io_ctrl
  import sram_io_ctrl_pkg::*;
#(
  parameter int MEMORY_DATA_WIDTH = sram_io_ctrl_pkg::MEMORY_DATA_WIDTH,
  parameter int MEMORY_ADDR_WIDTH = sram_io_ctrl_pkg::MEMORY_ADDR_WIDTH,
  parameter int REG_BITS_WIDTH    = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         BGN,
  input  logic                         SI,
  input  logic                         LOAD_N,
  input  logic [1:0]                   CTRL,
  input  logic [MEMORY_DATA_WIDTH-1:0] PI,
  output logic                         RDY,
  output logic                         D_WE,
  output logic                         CEN,
  output logic                         SO,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] PO
);

  localparam int CNT_W = $clog2(REG_BITS_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(REG_BITS_WIDTH - 1);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 rdy_q, cen_q, we_q;
  logic [REG_BITS_WIDTH-1:0] reg_bits;

  logic shift_en, load_en, inc_cond, addr_inc;

  // Datapath strobes are qualified by BGN so an abort edge never moves
  // reg_bits.
  assign shift_en = BGN && (state_q == ST_SHIFT);
  assign load_en  = BGN && (state_q == ST_READ_CAP);
  assign inc_cond = BGN && ((state_q == ST_WRITE) || (state_q == ST_READ_CAP));

`ifdef SRAM_IO_CTRL_AUTOINC_EN
  assign addr_inc = inc_cond;
`else
  assign addr_inc = 1'b0 & inc_cond;
`endif

  sram_io_shreg #(
    .DW (MEMORY_DATA_WIDTH),
    .AW (MEMORY_ADDR_WIDTH)
  ) u_shreg (
    .clk_i       (CLK),
    .rst_n_i     (RST_N),
    .shift_en_i  (shift_en),
    .si_i        (SI),
    .load_en_i   (load_en),
    .load_data_i (PI),
    .addr_inc_i  (addr_inc),
    .reg_bits_o  (reg_bits)
  );

  // CTRL is decoded straight into the next state on the trigger edge, so
  // the state register itself holds the latched mode; later CTRL/LOAD_N
  // activity is never looked at. CEN/D_WE are registered and asserted on
  // entry to WRITE/READ, released on the following edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      cen_q   <= 1'b1;
      we_q    <= 1'b1;
    end else begin
      cen_q <= 1'b1;
      we_q  <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          rdy_q <= 1'b0;
          if (BGN && !LOAD_N) begin
            case (CTRL)
              MODE_SHIFT: begin
                state_q <= ST_SHIFT;
                cnt_q   <= '0;
              end
              MODE_WRITE: begin
                state_q <= ST_WRITE;
                cen_q   <= 1'b0;
                we_q    <= 1'b0;
              end
              MODE_READ: begin
                state_q <= ST_READ;
                cen_q   <= 1'b0;
              end
              default: begin
                state_q <= ST_DONE;
                rdy_q   <= 1'b1;
              end
            endcase
          end
        end
        ST_SHIFT: begin
          if (!BGN) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == LAST_BIT) begin
            state_q <= ST_DONE;
            rdy_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WRITE: begin
          if (!BGN) state_q <= ST_IDLE;
          else begin
            state_q <= ST_DONE;
            rdy_q   <= 1'b1;
          end
        end
        ST_READ: begin
          if (!BGN) state_q <= ST_IDLE;
          else      state_q <= ST_READ_CAP;
        end
        ST_READ_CAP: begin
          if (!BGN) state_q <= ST_IDLE;
          else begin
            state_q <= ST_DONE;
            rdy_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!BGN) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign RDY  = rdy_q;
  assign CEN  = cen_q;
  assign D_WE = we_q;
  assign SO   = reg_bits[0];
  assign A    = reg_bits[REG_BITS_WIDTH-1:MEMORY_DATA_WIDTH];
  assign PO   = reg_bits[MEMORY_DATA_WIDTH-1:0];

endmodule

// File: tb/tb_sram_io_ctrl.sv
module tb_sram_io_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N, BGN, SI, LOAD_N;
  logic [1:0] CTRL;
  logic [7:0] PI;
  logic       RDY, D_WE, CEN, SO;
  logic [8:0] A;
  logic [7:0] PO;

  sram_io_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .BGN(BGN), .SI(SI), .LOAD_N(LOAD_N),
    .CTRL(CTRL), .PI(PI), .RDY(RDY), .D_WE(D_WE), .CEN(CEN), .SO(SO),
    .A(A), .PO(PO)
  );

  always #5 CLK = ~CLK;

  // 512x8 SRAM with registered Q
  logic [7:0] mem [512];
  always @(posedge CLK) begin
    if (!CEN) begin
      if (!D_WE) mem[A] <= PO;
      else       PI <= mem[A];
    end
  end

`ifdef SRAM_IO_CTRL_AUTOINC_EN
  localparam logic [8:0] INC = 9'd1;
`else
  localparam logic [8:0] INC = 9'd0;
`endif

  localparam logic [1:0] SH = 2'b00, RD = 2'b01, NP = 2'b10, WR = 2'b11;

  typedef struct {
    logic [1:0]  ctrl;
    logic [16:0] word;
    logic [8:0]  exp_a;
    logic [7:0]  exp_po;
    int          exp_lat;
    int          exp_cen;
    int          exp_we;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] c, input logic [16:0] w,
                              input logic [8:0] ea, input logic [7:0] ep,
                              input int lat, input int cen, input int we);
    vec_t v;
    v.ctrl = c; v.word = w; v.exp_a = ea; v.exp_po = ep;
    v.exp_lat = lat; v.exp_cen = cen; v.exp_we = we;
    return v;
  endfunction

  function automatic vec_t sh(input logic [8:0] a, input logic [7:0] d);
    return mk(SH, {a, d}, a, d, 18, 0, 0);
  endfunction

  // Start an operation, scramble CTRL/LOAD_N afterwards, feed SI bits,
  // then check latency, SRAM strobes, fields and RDY release.
  task automatic run_op(input vec_t v, input string nm);
    int lat, cen_n, we_n;
    bit got;
    @(negedge CLK);
    BGN = 1'b1; CTRL = v.ctrl; LOAD_N = 1'b0;
    lat = 0; cen_n = 0; we_n = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      LOAD_N = 1'b1;
      CTRL   = ~v.ctrl;
      SI     = (i < 17) ? v.word[i] : 1'b0;
      lat++;
      if (!CEN)  cen_n++;
      if (!D_WE) we_n++;
      if (RDY)   got = 1;
    end
    chk({nm, " rdy_seen"}, 32'(got), 32'd1);
    chk({nm, " latency"}, lat, v.exp_lat);
    chk({nm, " cen_cycles"}, cen_n, v.exp_cen);
    chk({nm, " we_cycles"}, we_n, v.exp_we);
    chk({nm, " A"}, A, v.exp_a);
    chk({nm, " PO"}, PO, v.exp_po);
    chk({nm, " SO"}, SO, v.exp_po[0]);
    BGN = 1'b0;
    @(negedge CLK);
    chk({nm, " rdy_drop"}, RDY, 1'b0);
    CTRL = NP;
  endtask

  vec_t tbl[14];

  initial begin
    int cen_n;
    logic [8:0] ad;
    logic [7:0] dt;

    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    PI = 8'h00;

    tbl[0]  = sh(9'h020, 8'h04);
    tbl[1]  = mk(WR, 17'h0, 9'h020 + INC, 8'h04, 2, 1, 1);
    tbl[2]  = sh(9'h021, 8'hA5);
    tbl[3]  = mk(WR, 17'h0, 9'h021 + INC, 8'hA5, 2, 1, 1);
    tbl[4]  = sh(9'h1FF, 8'h3C);
    tbl[5]  = mk(WR, 17'h0, 9'h1FF + INC, 8'h3C, 2, 1, 1);
    tbl[6]  = sh(9'h020, 8'h00);
    tbl[7]  = mk(RD, 17'h0, 9'h020 + INC, 8'h04, 3, 1, 0);
    tbl[8]  = sh(9'h021, 8'h00);
    tbl[9]  = mk(RD, 17'h0, 9'h021 + INC, 8'hA5, 3, 1, 0);
    tbl[10] = sh(9'h1FF, 8'h00);
    tbl[11] = mk(RD, 17'h0, 9'h1FF + INC, 8'h3C, 3, 1, 0);
    tbl[12] = mk(NP, 17'h0, 9'h1FF + INC, 8'h3C, 1, 0, 0);
    tbl[13] = sh(9'h155, 8'hFF);

    // reset
    RST_N = 1'b0; BGN = 1'b0; SI = 1'b0; LOAD_N = 1'b1; CTRL = NP;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset RDY", RDY, 1'b0);
    chk("reset CEN", CEN, 1'b1);
    chk("reset D_WE", D_WE, 1'b1);
    chk("reset A", A, 9'h000);
    chk("reset PO", PO, 8'h00);
    RST_N = 1'b1;

    for (int i = 0; i < 14; i++) run_op(tbl[i], $sformatf("vec%0d", i));
    chk("mem[020]", mem[9'h020], 8'h04);
    chk("mem[1FF]", mem[9'h1FF], 8'h3C);

    // 14-byte block write then read-back
    for (int i = 0; i < 14; i++) begin
      ad = 9'h020 + 9'(i);
      dt = 8'h30 + 8'(i * 11);
      run_op(sh(ad, dt), $sformatf("blk_ld%0d", i));
      run_op(mk(WR, 17'h0, ad + INC, dt, 2, 1, 1), $sformatf("blk_wr%0d", i));
    end
    for (int i = 0; i < 14; i++) begin
      ad = 9'h020 + 9'(i);
      dt = 8'h30 + 8'(i * 11);
      run_op(sh(ad, 8'h00), $sformatf("rb_ld%0d", i));
      run_op(mk(RD, 17'h0, ad + INC, dt, 3, 1, 0), $sformatf("rb_rd%0d", i));
    end

    // abort after 8 shifts of ones into a cleared register
    run_op(sh(9'h000, 8'h00), "abort_clr");
    @(negedge CLK);
    BGN = 1'b1; CTRL = SH; LOAD_N = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      LOAD_N = 1'b1; SI = 1'b1;
    end
    @(negedge CLK);
    BGN = 1'b0;
    cen_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk($sformatf("abort RDY%0d", i), RDY, 1'b0);
      if (!CEN) cen_n++;
    end
    chk("abort cen_cycles", cen_n, 0);
    chk("abort A", A, 9'h1FE);
    chk("abort PO", PO, 8'h00);
    run_op(sh(9'h0AB, 8'h5A), "after_abort");

    // reset in the middle of a shift
    @(negedge CLK);
    BGN = 1'b1; CTRL = SH; LOAD_N = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      LOAD_N = 1'b1; SI = 1'b1;
    end
    RST_N = 1'b0;
    @(negedge CLK);
    chk("midrst RDY", RDY, 1'b0);
    chk("midrst CEN", CEN, 1'b1);
    chk("midrst A", A, 9'h000);
    chk("midrst PO", PO, 8'h00);
    RST_N = 1'b1; BGN = 1'b0;
    run_op(sh(9'h1C3, 8'h81), "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
